// File: rtl/game_input_conditioner.sv
// game_input_conditioner
// Per-button conditioning for raw push-buttons: two-flop synchronizer,
// debounce counter, rising-edge press pulse and a sticky request that holds
// a press until the consumer's sample strobe (tick_i) has observed it.
// All channels are independent copies of the same datapath.

module game_input_conditioner #(
    parameter int num_buttons_p     = 4,
    parameter int debounce_cycles_p = 5000
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [num_buttons_p-1:0] btn_raw_i,
    input  logic                     tick_i,
    output logic [num_buttons_p-1:0] btn_level_o,
    output logic [num_buttons_p-1:0] btn_press_o,
    output logic [num_buttons_p-1:0] btn_req_o
);

    // Counter is sized to hold N; it only ever reaches N-1 before wrapping to 0.
    localparam int cnt_w_lp = $clog2(debounce_cycles_p + 1);
    localparam logic [cnt_w_lp-1:0] cnt_max_lp = cnt_w_lp'(debounce_cycles_p - 1);
    localparam logic [cnt_w_lp-1:0] cnt_one_lp = cnt_w_lp'(1);
    localparam logic [cnt_w_lp-1:0] cnt_zero_lp = cnt_w_lp'(0);

    logic [num_buttons_p-1:0] sync1_q;
    logic [num_buttons_p-1:0] sync2_q;
    logic [num_buttons_p-1:0] stable_q;
    logic [num_buttons_p-1:0] stable_d;
    logic [num_buttons_p-1:0] press_q;
    logic [num_buttons_p-1:0] press_d;
    logic [num_buttons_p-1:0] sticky_q;
    logic [num_buttons_p-1:0] sticky_d;
    logic [cnt_w_lp-1:0]      cnt_q [num_buttons_p];
    logic [cnt_w_lp-1:0]      cnt_d [num_buttons_p];

    // Two-flop synchronizer bringing the asynchronous buttons into clk_i.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_raw_i;
            sync2_q <= sync1_q;
        end
    end

    // Next-state for debounce, press detect and sticky request, per channel.
    always_comb begin
        stable_d = stable_q;
        press_d  = '0;
        sticky_d = sticky_q;
        for (int i = 0; i < num_buttons_p; i++) begin
            cnt_d[i] = cnt_q[i];
        end
        for (int i = 0; i < num_buttons_p; i++) begin
            // A level must differ for N consecutive cycles before it is taken.
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = cnt_zero_lp;
            end else if (cnt_q[i] == cnt_max_lp) begin
                stable_d[i] = sync2_q[i];
                cnt_d[i]    = cnt_zero_lp;
                // Only an accepted 0->1 flip is a press; releases are silent.
                press_d[i]  = sync2_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + cnt_one_lp;
            end

            // A press on the same edge as a tick wins, so it is never lost.
            if (press_d[i]) begin
                sticky_d[i] = 1'b1;
            end else if (tick_i) begin
                sticky_d[i] = 1'b0;
            end else begin
                sticky_d[i] = sticky_q[i];
            end
        end
    end

    // Conditioning state registers; reset discards any partial debounce count.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stable_q <= '0;
            press_q  <= '0;
            sticky_q <= '0;
            for (int i = 0; i < num_buttons_p; i++) begin
                cnt_q[i] <= cnt_zero_lp;
            end
        end else begin
            stable_q <= stable_d;
            press_q  <= press_d;
            sticky_q <= sticky_d;
            for (int i = 0; i < num_buttons_p; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign btn_level_o = stable_q;
    assign btn_press_o = press_q;
    assign btn_req_o   = stable_q | sticky_q;

endmodule

// File: tb/tb_game_input_conditioner.sv
// Bench for game_input_conditioner (N = 4, four buttons). Directed scenarios
// followed by randomized traffic, every cycle compared with a window-based
// reference model: a level is accepted once the last N synchronized samples
// all disagree with the current level.

module tb_game_input_conditioner;

    localparam int NB = 4;
    localparam int N  = 4;

    logic          clk = 1'b0;
    logic          reset_s;
    logic          tick_s;
    logic [NB-1:0] raw_s;
    logic [NB-1:0] level_s;
    logic [NB-1:0] press_s;
    logic [NB-1:0] req_s;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Reference model state.
    logic [NB-1:0] m_level  = '0;
    logic [NB-1:0] m_press  = '0;
    logic [NB-1:0] m_sticky = '0;
    logic [NB-1:0] raw_hist[$];
    logic [NB-1:0] seen_hist[$];

    always #5 clk = ~clk;

    game_input_conditioner #(
        .num_buttons_p    (NB),
        .debounce_cycles_p(N)
    ) dut (
        .clk_i      (clk),
        .reset_i    (reset_s),
        .btn_raw_i  (raw_s),
        .tick_i     (tick_s),
        .btn_level_o(level_s),
        .btn_press_o(press_s),
        .btn_req_o  (req_s)
    );

    task automatic chk(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs applied to it.
    task automatic model_step(input logic [NB-1:0] r, input logic tk, input logic rst);
        logic [NB-1:0] seen;
        logic [NB-1:0] new_press;
        bit            all_diff;
        if (rst) begin
            raw_hist.delete();
            seen_hist.delete();
            m_level  = '0;
            m_press  = '0;
            m_sticky = '0;
        end else begin
            // The value judged on this edge was sampled from the pins two edges ago.
            seen = (raw_hist.size() >= 2) ? raw_hist[raw_hist.size()-2] : 4'h0;
            raw_hist.push_back(r);
            seen_hist.push_back(seen);
            if (raw_hist.size() > 8) void'(raw_hist.pop_front());
            if (seen_hist.size() > 8) void'(seen_hist.pop_front());
            new_press = 4'h0;
            for (int i = 0; i < NB; i++) begin
                all_diff = (seen_hist.size() >= N);
                if (all_diff) begin
                    for (int k = 0; k < N; k++) begin
                        if (seen_hist[seen_hist.size()-1-k][i] == m_level[i]) all_diff = 1'b0;
                    end
                end
                if (all_diff) begin
                    new_press[i] = ~m_level[i];
                    m_level[i]   = ~m_level[i];
                end
            end
            m_press  = new_press;
            m_sticky = new_press | (tk ? 4'h0 : m_sticky);
        end
    endtask

    // One clock: drive, let the edge happen, then compare away from the edge.
    task automatic cyc(input logic [NB-1:0] r, input logic tk, input logic rst);
        raw_s   = r;
        tick_s  = tk;
        reset_s = rst;
        @(posedge clk);
        model_step(r, tk, rst);
        @(negedge clk);
        chk("level", level_s, m_level);
        chk("press", press_s, m_press);
        chk("req", req_s, m_level | m_sticky);
    endtask

    initial begin
        logic [NB-1:0] rnd_raw;
        logic          rnd_tick;
        logic          rnd_rst;

        raw_s   = 4'hF;
        tick_s  = 1'b0;
        reset_s = 1'b1;

        // Reset with all buttons held, then re-acceptance after release.
        repeat (3) begin
            cyc(4'hF, 1'b0, 1'b1);
            chk("rst_level", level_s, 4'h0);
            chk("rst_req", req_s, 4'h0);
        end
        repeat (5) cyc(4'hF, 1'b0, 1'b0);
        chk("s1_level_early", level_s, 4'h0);
        cyc(4'hF, 1'b0, 1'b0);
        chk("s1_level", level_s, 4'hF);
        chk("s1_press", press_s, 4'hF);
        cyc(4'hF, 1'b0, 1'b0);
        chk("s1_press_end", press_s, 4'h0);
        repeat (8) cyc(4'h0, 1'b0, 1'b0);
        chk("s1_sticky", req_s, 4'hF);
        cyc(4'h0, 1'b1, 1'b0);
        chk("s1_cleared", req_s, 4'h0);

        // Clean press on left, held across ticks.
        repeat (5) cyc(4'h1, 1'b0, 1'b0);
        chk("s2_level_early", level_s, 4'h0);
        cyc(4'h1, 1'b0, 1'b0);
        chk("s2_level", level_s, 4'h1);
        chk("s2_press", press_s, 4'h1);
        cyc(4'h1, 1'b0, 1'b0);
        chk("s2_press_end", press_s, 4'h0);
        for (int k = 0; k < 10; k++) begin
            cyc(4'h1, (k == 3 || k == 7), 1'b0);
            chk("s2_req_held", req_s, 4'h1);
        end
        repeat (8) cyc(4'h0, 1'b0, 1'b0);
        chk("s2_release", req_s, 4'h0);

        // Glitchy right button never reaches the outputs.
        foreach (raw_hist[j]) begin end
        for (int k = 0; k < 14; k++) begin
            cyc(((k < 3) || (k >= 4 && k < 7)) ? 4'h2 : 4'h0, 1'b0, 1'b0);
            chk("s3_glitch", level_s | press_s | req_s, 4'h0);
        end

        // Short tap on rotate survives until the first tick.
        repeat (5) cyc(4'h4, 1'b0, 1'b0);
        cyc(4'h4, 1'b0, 1'b0);
        chk("s4_req_rise", req_s, 4'h4);
        repeat (8) cyc(4'h0, 1'b0, 1'b0);
        chk("s4_level_fell", level_s, 4'h0);
        chk("s4_req_sticky", req_s, 4'h4);
        cyc(4'h0, 1'b1, 1'b0);
        chk("s4_tick1", req_s, 4'h0);
        cyc(4'h0, 1'b1, 1'b0);
        chk("s4_tick2", req_s, 4'h0);

        // Tick collides with the start press edge; the set wins.
        repeat (5) cyc(4'h8, 1'b0, 1'b0);
        cyc(4'h8, 1'b1, 1'b0);
        chk("s5_press", press_s, 4'h8);
        chk("s5_req", req_s, 4'h8);
        repeat (8) cyc(4'h0, 1'b0, 1'b0);
        chk("s5_req_kept", req_s, 4'h8);
        cyc(4'h0, 1'b1, 1'b0);
        chk("s5_cleared", req_s, 4'h0);

        // Two channels together, reset mid-count restarts the debounce.
        repeat (2) cyc(4'h3, 1'b0, 1'b0);
        cyc(4'h3, 1'b0, 1'b1);
        chk("s6_reset", level_s | req_s, 4'h0);
        for (int k = 0; k < 5; k++) begin
            cyc(4'h3, 1'b0, 1'b0);
            chk("s6_level_early", level_s, 4'h0);
        end
        cyc(4'h3, 1'b0, 1'b0);
        chk("s6_level", level_s, 4'h3);
        chk("s6_press", press_s, 4'h3);
        repeat (8) cyc(4'h0, 1'b0, 1'b0);
        cyc(4'h0, 1'b1, 1'b0);

        // Randomized traffic: slow button changes, sparse ticks and resets.
        rnd_raw = 4'h0;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 7) == 0) rnd_raw[$urandom_range(0, NB-1)] ^= 1'b1;
            rnd_tick = ($urandom_range(0, 9) == 0);
            rnd_rst  = ($urandom_range(0, 199) == 0);
            cyc(rnd_raw, rnd_tick, rnd_rst);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/game_input_conditioner.md
# game_input_conditioner

Conditions the raw, asynchronous push-button inputs (left, right, rotate, start) before they reach the game top logic. Each button is synchronized, debounced, edge-detected and held as a sticky request until the consumer's sample strobe has seen it. The `btn_req_o` bits drive the top logic's `left_i`, `right_i`, `rotate_i` and `start_i`, and `tick_i` is driven by the top logic's 4 Hz sample pulse. This guarantees that a short tap between two samples is never lost, and that a held button repeats once per sample.

## Interface
Parameters:
- `num_buttons_p`, default 4: number of button channels. Bit 0 = left, 1 = right, 2 = rotate, 3 = start.
- `debounce_cycles_p`, default 5000: N, the number of consecutive clock cycles a changed level must persist before it is accepted. Minimum 1. The default is 5 ms at 1 MHz.

Ports:
- `clk_i`, in, 1: system clock (1 MHz).
- `reset_i`, in, 1: reset. One clock; reset is synchronous and active-high.
- `btn_raw_i`, in, `num_buttons_p`: raw buttons, asynchronous, active-high.
- `tick_i`, in, 1: consumer sample strobe, one cycle wide. Clears sticky requests.
- `btn_level_o`, out, `num_buttons_p`: debounced button level.
- `btn_press_o`, out, `num_buttons_p`: one-cycle pulse on each debounced 0->1 transition.
- `btn_req_o`, out, `num_buttons_p`: request to the consumer, equal to `btn_level_o | sticky`.

## Operation
The following applies independently to each channel i.

**Synchronizer**
- Two flops: `sync1 <= btn_raw_i[i]`, then `sync2 <= sync1`.

**Debounce counter**
- The counter is `$clog2(N+1)` bits wide. `stable` is the accepted level and drives `btn_level_o[i]`.
- Every edge, in priority order:
  - If `sync2 == stable`: `cnt <= 0`.
  - Else if `cnt == N-1`: `stable <= sync2` and `cnt <= 0`.
  - Else: `cnt <= cnt + 1`.
- A return to the stable value before N consecutive differing cycles resets the count. Glitches shorter than N cycles never reach the outputs.

**Press detect**
- `btn_press_o[i]` is registered. It is set to 1 on the edge where `stable` flips 0->1 and is 0 on every other edge.
- A release (1->0 flip) produces no pulse.

**Sticky request**
- On `press`, `sticky <= 1`. This happens on the same edge that `btn_press_o` is set.
- Else if `tick_i`, `sticky <= 0`.
- If a press and `tick_i` occur on the same edge, the set wins: the request survives until the next `tick_i`.
- `btn_req_o[i] = btn_level_o[i] | sticky`. This is combinational from registered state.

**Consequences for the consumer**
- A held button is seen high at every `tick_i`. This gives auto-repeat at the tick rate.
- A tap shorter than the tick period is seen high at exactly one `tick_i` (the first after the press), then drops.

**Channel independence**
- Channels are fully independent. No priority or mutual exclusion is applied; that is left to the consumer.

## Timing
- **Reset:** `reset_i` synchronously clears `sync1`, `sync2`, `stable`, `cnt`, `sticky` and the press register. All outputs read 0 in the cycle after the reset edge.
- **Reset mid-debounce:** partial counts are discarded.
- **Button held through reset:** it is re-accepted N+1 edges after the first non-reset edge, and it generates a fresh press pulse.
- **Latency:** let edge 0 be the first edge that samples the new raw value, with the value then held.
  - `btn_level_o` and `btn_press_o` change on edge N+1.
  - `btn_req_o` rises on edge N+1.
  - Release: `btn_level_o` falls on edge N+1. `btn_req_o` falls at the later of that edge and the first `tick_i` edge after the press.
- **Minimum N = 1:** a flip happens on edge 2, the first edge `sync2` differs.
- **Counter wrap:** the counter never exceeds N-1.
- **Press pulse width:** exactly one cycle. Back-to-back presses need at least N cycles released between them; each accepted rise gives one pulse.
- **`tick_i` held high:** behaves as a clear on every edge; a press still sets `sticky` for that edge.

## Test plan
All scenarios use `debounce_cycles_p = 4` and `num_buttons_p = 4`.
1. **Reset:** assert `reset_i` 3 cycles with `btn_raw_i = 4'hF` -> all outputs 0 during reset. `btn_level_o = 4'hF` and `btn_press_o = 4'hF` for one cycle, on edge 5 after reset release.
2. **Clean press:** raw[0] rises before edge 0 and stays -> `btn_level_o[0]` = 1 and `btn_press_o[0]` = 1 after edge 5. `btn_press_o[0]` returns to 0 after edge 6. `btn_req_o[0]` stays 1 while held, including across `tick_i`.
3. **Glitch:** raw[1] high for 3 cycles, low for 1, high for 3, then low -> `btn_level_o[1]`, `btn_press_o[1]` and `btn_req_o[1]` stay 0 throughout.
4. **Short tap:** raw[2] high for 6 cycles, no tick -> `btn_req_o[2]` rises on edge 5 and remains 1 after level falls. The first `tick_i` pulse clears it on that edge. A second `tick_i` sees 0.
5. **Set/clear collision:** `tick_i` asserted on the same edge `btn_press_o[3]` rises -> `btn_req_o[3]` remains 1 after release until the next `tick_i`.
6. **Independence and reset mid-count:** raw[0] and raw[1] both rise, then `reset_i` pulses 2 edges later -> no outputs assert. After release the count restarts, and `btn_level_o = 4'h3` appears 5 edges after the first post-reset edge.
